// File: rtl/sys_pkg.sv
// sys_pkg: shared operand types and feed-state encoding for the systolic matmul datapath
package sys_pkg;
    localparam int DATA_W = 8;
    localparam int ACC_W = 16;
    typedef logic [DATA_W-1:0] data_t;
    typedef enum logic {LOAD, FEED} feed_state_t;
endpackage

// File: rtl/sys_in_skew.sv
// sys_in_skew: buffers one A/B matrix pair from a serial beat stream and replays it as zero-padded skewed wavefronts
// Ports: CLK/rst (sync, active-high); in_vld/in_rdy/a_in/b_in load handshake (beat n -> A[n%M][n/M], B[n/M][n%M]);
//        arr_vld/arr_rdy wavefront handshake; arr_a row lanes, arr_b column lanes; arr_first/arr_last mark t=0 and t=3M-3.
module sys_in_skew #(
    parameter int M = 3,
    parameter int DATA_W = sys_pkg::DATA_W
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [DATA_W-1:0]   a_in,
    input  logic [DATA_W-1:0]   b_in,
    output logic                arr_vld,
    input  logic                arr_rdy,
    output logic [M*DATA_W-1:0] arr_a,
    output logic [M*DATA_W-1:0] arr_b,
    output logic                arr_first,
    output logic                arr_last
);
    import sys_pkg::*;
    localparam int NW = (M * M > 1) ? $clog2(M * M) : 1;
    localparam int TW = (3 * M - 2 > 1) ? $clog2(3 * M - 2) : 1;
    localparam int KW = (M > 1) ? $clog2(M) : 1;
    feed_state_t state;
    logic [NW-1:0] n;
    logic [KW-1:0] ii, kk;
    logic [TW-1:0] t;
    logic [DATA_W-1:0] a_buf [M][M];
    logic [DATA_W-1:0] b_buf [M][M];
    logic load_fire, feed_fire, n_last, t_last;
    assign load_fire = (state == LOAD) && in_vld;
    assign feed_fire = (state == FEED) && arr_rdy;
    assign n_last = n == NW'(M * M - 1);
    assign t_last = t == TW'(3 * M - 3);
    // ii/kk track n%M and n/M incrementally so no divider is needed
    always_ff @(posedge CLK) begin
        if (load_fire) begin
            a_buf[ii][kk] <= a_in;
            b_buf[kk][ii] <= b_in;
        end
    end
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= LOAD;
            n <= '0;
            ii <= '0;
            kk <= '0;
            t <= '0;
        end else if (load_fire) begin
            n <= n_last ? '0 : n + 1'b1;
            ii <= (ii == KW'(M - 1)) ? '0 : ii + 1'b1;
            kk <= n_last ? '0 : (ii == KW'(M - 1)) ? kk + 1'b1 : kk;
            t <= '0;
            state <= n_last ? FEED : LOAD;
        end else if (feed_fire) begin
            t <= t_last ? '0 : t + 1'b1;
            state <= t_last ? LOAD : FEED;
        end
    end
    assign in_rdy = state == LOAD;
    assign arr_vld = state == FEED;
    assign arr_first = arr_vld && (t == '0);
    assign arr_last = arr_vld && t_last;
    // lane i carries element index t-i while it lies inside the matrix, zero in the skew triangles
    for (genvar i = 0; i < M; i++) begin : g_lane
        logic [KW-1:0] idx;
        logic hit;
        assign idx = KW'(t - TW'(i));
        assign hit = arr_vld && (t >= TW'(i)) && (t < TW'(i + M));
        assign arr_a[DATA_W*i +: DATA_W] = hit ? a_buf[i][idx] : '0;
        assign arr_b[DATA_W*i +: DATA_W] = hit ? b_buf[idx][i] : '0;
    end
endmodule

// File: tb/tb_sys_in_skew.sv
// tb_sys_in_skew: scoreboard bench for sys_in_skew with hand-computed wavefront tables (M=3)
module tb_sys_in_skew;
    localparam int M = 3;
    logic clk = 0, rst = 1, in_vld = 0, arr_rdy = 1;
    logic [7:0] a_in = 0, b_in = 0;
    logic in_rdy, arr_vld, arr_first, arr_last;
    logic [23:0] arr_a, arr_b;
    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic first;
        logic last;
        int t;
    } wave_t;
    wave_t q[$];
    wave_t e;
    int compared = 0, mismatched = 0, accepted = 0;
    logic [7:0] id_av [9] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    logic [7:0] id_bv [9] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    logic [23:0] id_w [7] = '{24'h000001, 24'h0, 24'h000100, 24'h0, 24'h010000, 24'h0, 24'h0};
    logic [7:0] g_av [9] = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1};
    logic [7:0] g_bv [9] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd2, 8'd0, 8'd1};
    logic [23:0] g_wa [7] = '{24'h000001, 24'h000001, 24'h000100, 24'h010000, 24'h010000, 24'h0, 24'h0};
    logic [23:0] g_wb [7] = '{24'h000001, 24'h000000, 24'h000202, 24'h000000, 24'h010000, 24'h0, 24'h0};

    sys_in_skew #(.M(M), .DATA_W(8)) dut (
        .CLK(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .a_in(a_in), .b_in(b_in),
        .arr_vld(arr_vld), .arr_rdy(arr_rdy), .arr_a(arr_a), .arr_b(arr_b),
        .arr_first(arr_first), .arr_last(arr_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        compared++;
        mismatched++;
        $display("FAIL %s: got timeout expected completion", nm);
    endtask

    // monitor: compares every presented wavefront with the queue head, pops on acceptance
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (arr_vld === 1'b1) begin
                if (q.size() == 0) begin
                    timeout("unexpected_wavefront");
                end else begin
                    e = q[0];
                    chk($sformatf("arr_a_t%0d", e.t), {24'h0, arr_a}, {24'h0, e.a});
                    chk($sformatf("arr_b_t%0d", e.t), {24'h0, arr_b}, {24'h0, e.b});
                    chk($sformatf("arr_first_t%0d", e.t), {47'h0, arr_first}, {47'h0, e.first});
                    chk($sformatf("arr_last_t%0d", e.t), {47'h0, arr_last}, {47'h0, e.last});
                    if (arr_rdy) begin
                        void'(q.pop_front());
                        accepted++;
                    end
                end
            end else begin
                chk("idle_lanes_zero", {arr_a, arr_b}, 48'h0);
            end
        end
    end

    task automatic load(input logic [7:0] av [9], input logic [7:0] bv [9],
                        input logic [23:0] wa [7], input logic [23:0] wb [7], input bit hold);
        int c;
        for (int t = 0; t < 7; t++) q.push_back('{wa[t], wb[t], t == 0, t == 6, t});
        for (int n = 0; n < 9; n++) begin
            a_in = av[n];
            b_in = bv[n];
            in_vld = 1;
            c = 0;
            while (!in_rdy && c < 50) begin
                @(posedge clk);
                #1;
                c++;
            end
            if (c >= 50) timeout("load_wait_in_rdy");
            @(posedge clk);
            #1;
        end
        in_vld = hold;
        a_in = hold ? 8'h55 : 8'h00;
        b_in = hold ? 8'h55 : 8'h00;
    endtask

    task automatic drain(input bit stall, input int acc0);
        int c;
        bit stalled;
        c = 0;
        stalled = 0;
        while (q.size() != 0 && c < 200) begin
            if (stall && !stalled && q.size() == 4) begin
                stalled = 1;
                arr_rdy = 0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                arr_rdy = 1;
            end else begin
                @(posedge clk);
                #1;
                c++;
                if (q.size() != 0) chk("in_rdy_during_feed", {47'h0, in_rdy}, 48'h0);
            end
        end
        if (c >= 200) timeout("drain");
        chk("in_rdy_after_last", {47'h0, in_rdy}, 48'h1);
        chk("accepted_wavefronts", 48'(accepted - acc0), 48'd7);
    endtask

    task automatic chk_reset_state();
        chk("rst_in_rdy", {47'h0, in_rdy}, 48'h1);
        chk("rst_arr_vld", {47'h0, arr_vld}, 48'h0);
        chk("rst_lanes", {arr_a, arr_b}, 48'h0);
        chk("rst_first_last", {46'h0, arr_first, arr_last}, 48'h0);
    endtask

    initial begin
        int c;
        rst = 1;
        in_vld = 1;
        a_in = 8'haa;
        b_in = 8'haa;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_reset_state();
        end
        rst = 0;
        in_vld = 0;
        load(id_av, id_bv, id_w, id_w, 0);
        drain(0, accepted - 0);
        c = accepted;
        load(g_av, g_bv, g_wa, g_wb, 0);
        drain(0, c);
        c = accepted;
        load(g_av, g_bv, g_wa, g_wb, 0);
        drain(1, c);
        c = accepted;
        load(g_av, g_bv, g_wa, g_wb, 1);
        drain(0, c);
        c = accepted;
        load(id_av, id_bv, id_w, id_w, 0);
        drain(0, c);
        load(g_av, g_bv, g_wa, g_wb, 0);
        c = 0;
        while (q.size() != 5 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 50) timeout("wait_t2");
        rst = 1;
        arr_rdy = 0;
        @(posedge clk);
        #1;
        rst = 0;
        arr_rdy = 1;
        q.delete();
        chk_reset_state();
        c = accepted;
        load(id_av, id_bv, id_w, id_w, 0);
        drain(0, c);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end
endmodule
